// File: rtl/ex_pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: channel state
// encoding, default sizing and the config-channel index width helper.
package ex_pwm_pkg;

  localparam int PWM_NUM_CH = 4;
  localparam int PWM_CNT_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pwm_state_e;

  // Width of the channel select field; at least one bit even for one channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ex_pwm_chan.sv
// One PWM channel: active and shadow configuration, pending-apply handshake,
// IDLE/RUN/DONE sequencing, period counter and registered outputs.
module ex_pwm_chan
  import ex_pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_high,
  input  logic             i_oneshot,
  output logic             o_pend,
  output logic             o_pwm,
  output logic             o_tick,
  output logic             o_busy
);

  pwm_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_per, r_high, w_per_nx, w_high_nx;
  logic [CNT_W-1:0] r_sh_per, r_sh_high;
  logic             r_os, r_sh_os, w_os_nx;
  logic             r_pend, w_pend_nx;
  logic             r_pwm, w_pwm_nx;
  logic             r_tick;
  logic             w_wrap, w_apply;

  // Next-state, counter, config-apply and waveform decisions for this edge.
  // RUN never holds a zero period, so period-1 cannot underflow there.
  always_comb begin
    w_wrap    = (r_state == ST_RUN) && i_en && (r_cnt == r_per - CNT_W'(1));
    w_apply   = r_pend && (w_wrap || (r_state != ST_RUN));
    w_per_nx  = w_apply ? r_sh_per  : r_per;
    w_high_nx = w_apply ? r_sh_high : r_high;
    w_os_nx   = w_apply ? r_sh_os   : r_os;

    w_pend_nx = r_pend;
    if (i_wr) begin
      w_pend_nx = 1'b1;
    end else if (w_apply) begin
      w_pend_nx = 1'b0;
    end

    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (!i_en) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_per_nx != '0) begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = '0;
          end
        end
        ST_RUN: begin
          if (w_wrap) begin
            w_cnt_nx = '0;
            if (w_per_nx == '0) begin
              w_state_nx = ST_IDLE;
            end else if (r_os && !w_apply) begin
              w_state_nx = ST_DONE;
            end
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (w_apply) begin
            w_cnt_nx   = '0;
            w_state_nx = (w_per_nx != '0) ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end

    w_pwm_nx = (w_state_nx == ST_RUN) && (w_cnt_nx < w_high_nx);
  end

  // State, counter, config and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_per     <= '0;
      r_high    <= '0;
      r_os      <= 1'b0;
      r_sh_per  <= '0;
      r_sh_high <= '0;
      r_sh_os   <= 1'b0;
      r_pend    <= 1'b0;
      r_pwm     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_per   <= w_per_nx;
      r_high  <= w_high_nx;
      r_os    <= w_os_nx;
      r_pend  <= w_pend_nx;
      r_pwm   <= w_pwm_nx;
      r_tick  <= w_wrap;
      if (i_wr) begin
        r_sh_per  <= i_period;
        r_sh_high <= i_high;
        r_sh_os   <= i_oneshot;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_pwm  = r_pwm;
  assign o_tick = r_tick;
  assign o_busy = (r_state == ST_RUN);

endmodule

// File: rtl/ex_pwm_gen.sv
// Multi-channel PWM generator top: config decode, cfg_ready mux and one
// independent ex_pwm_chan per output channel.
module ex_pwm_gen
  import ex_pwm_pkg::*;
#(
  parameter  int NUM_CH = PWM_NUM_CH,
  parameter  int CNT_W  = PWM_CNT_W,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic              safe_clk,
  input  logic              safe_reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] period_tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] w_pend;
  logic [NUM_CH-1:0] w_wr;

  // Ready mirrors the target channel's free shadow slot; an out-of-range
  // channel is always ready so its write is swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !w_pend[i];
      end
    end
  end

  // Per-channel shadow write strobes for accepted transfers.
  always_comb begin
    w_wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ex_pwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .i_clk    (safe_clk),
      .i_rst_n  (safe_reset_n),
      .i_en     (ch_en[gi]),
      .i_wr     (w_wr[gi]),
      .i_period (cfg_period),
      .i_high   (cfg_high),
      .i_oneshot(cfg_oneshot),
      .o_pend   (w_pend[gi]),
      .o_pwm    (pwm_out[gi]),
      .o_tick   (period_tick[gi]),
      .o_busy   (busy[gi])
    );
  end

endmodule

// File: tb/tb_ex_pwm_gen.sv
// Bench for ex_pwm_gen: each period is modelled as a queue of future output
// bits (high ones then low zeros); compared every cycle plus literal checks.
module tb_ex_pwm_gen;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_high;
  logic           cfg_oneshot;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] pwm_out;
  logic [NCH-1:0] period_tick;
  logic [NCH-1:0] busy;

  int total = 0;
  int bad   = 0;

  ex_pwm_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .safe_clk    (clk),
    .safe_reset_n(rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_oneshot (cfg_oneshot),
    .ch_en       (ch_en),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: per channel, the remaining output bits of the current period.
  bit m_q [NCH][$];
  bit m_run [NCH];
  bit m_fin [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];
  int a_per [NCH];
  int a_high [NCH];
  bit a_os [NCH];
  int s_per [NCH];
  int s_high [NCH];
  bit s_os [NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_q[c].delete();
        m_run[c] = 0; m_fin[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
        a_per[c] = 0; a_high[c] = 0; a_os[c] = 0;
        s_per[c] = 0; s_high[c] = 0; s_os[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        bit acc, ending, take;
        acc    = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
        ending = m_run[c] && ch_en[c] && (m_q[c].size() == 1);
        take   = m_pend[c] && (ending || !m_run[c]);
        if (take) begin
          a_per[c] = s_per[c]; a_high[c] = s_high[c]; a_os[c] = s_os[c];
          m_pend[c] = 0;
        end
        if (acc) begin
          s_per[c] = int'(cfg_period); s_high[c] = int'(cfg_high); s_os[c] = cfg_oneshot;
          m_pend[c] = 1;
        end
        m_tick[c] = ending;
        if (!ch_en[c]) begin
          m_q[c].delete(); m_run[c] = 0; m_fin[c] = 0;
        end else if (m_run[c]) begin
          void'(m_q[c].pop_front());
          if (m_q[c].size() == 0) begin
            if (a_per[c] == 0) m_run[c] = 0;
            else if (a_os[c] && !take) begin m_run[c] = 0; m_fin[c] = 1; end
            else for (int k = 0; k < a_per[c]; k++) m_q[c].push_back(k < a_high[c]);
          end
        end else if (!m_fin[c] || take) begin
          m_fin[c] = 0;
          if (a_per[c] != 0) begin
            for (int k = 0; k < a_per[c]; k++) m_q[c].push_back(k < a_high[c]);
            m_run[c] = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [NCH-1:0] e_pwm, e_tick, e_busy;
    logic           e_rdy;
    e_rdy = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      e_pwm[c]  = m_run[c] && (m_q[c].size() > 0) && m_q[c][0];
      e_tick[c] = m_tick[c];
      e_busy[c] = m_run[c];
      if (int'(cfg_ch) == c) e_rdy = !m_pend[c];
    end
    chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
    chk("period_tick", 32'(period_tick), 32'(e_tick));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int per, input int hi, input bit os);
    int n;
    n = 0;
    cfg_ch = CHW'(ch); cfg_period = CW'(per); cfg_high = CW'(hi); cfg_oneshot = os;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      step();
      n++;
    end
    chk("cfg_wait_bound", 32'(n < 50), 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  logic [19:0] cp, ct, cb, cr;

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0; cfg_oneshot = 1'b0;
    ch_en = '0;
    #12;
    chk("reset_outputs", {pwm_out, period_tick, busy}, 32'd0);
    chk("reset_ready", 32'(cfg_ready), 32'd1);
    #11 rst_n = 1'b1;
    step();

    // ch0 continuous 10/4
    ch_en = 3'b001;
    cfg_write(0, 10, 4, 0);
    step();
    cp = '0; ct = '0; cb = '0;
    for (int k = 0; k < 20; k++) begin
      cp[k] = pwm_out[0]; ct[k] = period_tick[0]; cb[k] = pwm_out[1] | pwm_out[2];
      step();
    end
    chk("cont_pwm0", 32'(cp), 32'h03C0F);
    chk("cont_tick0", 32'(ct), 32'h00400);
    chk("cont_other_pwm", 32'(cb), 32'h0);

    // period change written at count 3
    step(); step(); step();
    cfg_write(0, 6, 2, 0);
    cp = '0; ct = '0; cr = '0;
    for (int k = 0; k < 16; k++) begin
      cp[k] = pwm_out[0]; ct[k] = period_tick[0]; cr[k] = cfg_ready;
      step();
    end
    chk("chg_pwm0", 32'(cp), 32'h30C0);
    chk("chg_tick0", 32'(ct), 32'h1040);
    chk("chg_ready", 32'(cr), 32'hFFC0);

    // ch1 high > period, then period 0
    ch_en = 3'b011;
    cfg_write(1, 8, 12, 0);
    step();
    cp = '0; ct = '0; cb = '0;
    for (int k = 0; k < 20; k++) begin
      cp[k] = pwm_out[1]; ct[k] = period_tick[1]; cb[k] = busy[1];
      step();
    end
    chk("hi_gt_per_pwm1", 32'(cp), 32'hFFFFF);
    chk("hi_gt_per_tick1", 32'(ct), 32'h10100);
    chk("hi_gt_per_busy1", 32'(cb), 32'hFFFFF);
    cfg_write(1, 0, 5, 0);
    for (int k = 0; k < 10; k++) step();
    cp = '0; cb = '0;
    for (int k = 0; k < 5; k++) begin
      cp[k] = pwm_out[1]; cb[k] = busy[1];
      step();
    end
    chk("per0_pwm1", 32'(cp), 32'h0);
    chk("per0_busy1", 32'(cb), 32'h0);

    // ch1 one-shot 5/2, then re-armed with enable held
    for (int r = 0; r < 2; r++) begin
      cfg_write(1, 5, 2, 1);
      step();
      cp = '0; ct = '0; cb = '0;
      for (int k = 0; k < 8; k++) begin
        cp[k] = pwm_out[1]; ct[k] = period_tick[1]; cb[k] = busy[1];
        step();
      end
      chk("oneshot_pwm1", 32'(cp), 32'h03);
      chk("oneshot_tick1", 32'(ct), 32'h20);
      chk("oneshot_busy1", 32'(cb), 32'h1F);
    end

    // out-of-range channel is accepted and dropped
    cfg_ch = 2'd3;
    #1;
    chk("oob_ready", 32'(cfg_ready), 32'd1);
    cfg_write(3, 7, 3, 0);
    for (int k = 0; k < 4; k++) step();

    // enable drop stops channels
    ch_en = 3'b000;
    step(); step();
    chk("en_drop_busy", 32'(busy), 32'h0);
    ch_en = 3'b001;
    for (int k = 0; k < 4; k++) step();

    // asynchronous reset mid-period
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {pwm_out, period_tick, busy}, 32'd0);
    chk("async_rst_ready", 32'(cfg_ready), 32'd1);
    #20 rst_n = 1'b1;
    step();
    ct = '0; cb = '0;
    for (int k = 0; k < 15; k++) begin
      ct[k] = |period_tick; cb[k] = |busy;
      step();
    end
    chk("post_rst_tick", 32'(ct), 32'h0);
    chk("post_rst_busy", 32'(cb), 32'h0);

    cfg_write(0, 4, 1, 0);
    for (int k = 0; k < 12; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_pwm_gen.md
EX_PWM_GEN -- requirements
Module: ex_pwm_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent output channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the counter, period and high-time width (covers 1 s at 8 MHz).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports: safe_clk  in  1  sole clock; safe_reset_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have the following remaining ports:
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_ch  in  CH_W = max(1,$clog2(NUM_CH))  target channel.
- cfg_period  in  CNT_W  period in clocks.
- cfg_high  in  CNT_W  high time in clocks.
- cfg_oneshot  in  1  1 = one-shot, 0 = continuous.
- ch_en  in  NUM_CH  per-channel enable, level sensitive.
- pwm_out  out  NUM_CH  registered waveform.
- period_tick  out  NUM_CH  one-cycle pulse per completed period.
- busy  out  NUM_CH  channel running.

Function
REQ-005 Each channel SHALL hold active registers (period, high, oneshot) and a shadow set with a pending flag.
REQ-006 cfg_ready SHALL equal NOT pending[cfg_ch], combinationally; an accept is cfg_valid AND cfg_ready at a safe_clk edge.
REQ-007 On accept, the block SHALL load the shadow set of cfg_ch and set its pending flag; cfg_ch >= NUM_CH SHALL be accepted and discarded.
REQ-008 The block SHALL transfer a pending shadow set to the active set and clear pending:
- at the edge where the channel wraps; or
- at the first edge where the channel is not busy.
REQ-009 Channel states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on an edge with ch_en=1 and active period != 0; the counter loads 0 at that edge.
- RUN -> DONE at wrap when oneshot=1.
- RUN or DONE -> IDLE on an edge with ch_en=0.
- DONE -> RUN when a new config is applied while ch_en=1.
REQ-010 In RUN, the counter SHALL increment each clock, and at count == period-1 SHALL load 0 on the next edge (wrap); CNT_W arithmetic SHALL never overflow.
REQ-011 pwm_out[i] SHALL be registered and updated on the same edge as the counter: 1 iff in RUN and next count < high; high >= period gives a constant 1 and high = 0 gives a constant 0.
REQ-012 period_tick[i] SHALL be 1 for exactly the one cycle following each wrap edge, including the final wrap of a one-shot, and 0 otherwise.
REQ-013 busy[i] SHALL be 1 iff channel i is in RUN.
REQ-014 Active period = 0 SHALL keep the channel in IDLE with pwm_out 0 regardless of ch_en.
REQ-015 A config applied at wrap SHALL take effect from count 0 of the new period with no glitch; simultaneous accept and wrap on the same channel is impossible because pending blocks acceptance.
REQ-016 Channels SHALL be fully independent; an accept on one channel SHALL NOT affect timing of another.

Reset
REQ-017 While safe_reset_n = 0, the block SHALL asynchronously hold:
- all channels in IDLE;
- counters, active and shadow registers, and pending flags at 0;
- pwm_out, period_tick and busy at 0.
REQ-018 Reset deassertion SHALL be honoured at the next safe_clk edge, and reset asserted mid-period SHALL discard all state with no waveform completion.

Structure
REQ-019 A shared package ex_pwm_pkg SHALL hold the state enumeration (IDLE/RUN/DONE) and the default NUM_CH/CNT_W constants.
REQ-020 Per-channel logic SHALL be sub-module ex_pwm_chan, instantiated NUM_CH times by generate; the top level SHALL hold only the cfg decode and cfg_ready mux.

Verification
REQ-021 NUM_CH=2, CNT_W=8, ch0 period=10 high=4 continuous, ch_en=01 -> pwm_out[0] 4 high/6 low repeating, period_tick[0] every 10 clocks, ch1 stays 0.
REQ-022 Oneshot period=5 high=2, enable -> pwm_out 1,1,0,0,0, a single tick, busy falls after 5 clocks; a new config applied with ch_en held high restarts one period.
REQ-023 Running period=10, write period=6 at count 3 -> cfg_ready[ch] low until wrap, old period completes, next period is 6, cfg_ready returns high.
REQ-024 high=12, period=8 -> pwm_out constant 1; period=0 with ch_en=1 -> busy=0 and pwm_out=0.
REQ-025 safe_reset_n pulsed low mid-period, asynchronous to safe_clk -> all outputs 0 immediately, cfg_ready=1, no tick after release until re-enabled.
